mc_fsm_controller: RTL

Parametrised multicycle MIPS control unit that owns its own state register, replacing the external `S`/`NS` loop around the older combinational controller. It decodes `Op` and sequences Fetch → Decode → Execute/Memory → Writeback. Its control strobes drive the multicycle datapath: PC, IR, register file, ALU muxes and memory. It adds memory wait-state handshaking, optional `addi`/`bne` support, illegal-opcode trapping and an instruction-retire pulse.

---
 rtl/mc_pkg.sv | 62 ++++++
 rtl/mc_ctrl_decode.sv | 85 ++++++++
 rtl/mc_fsm_controller.sv | 96 +++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: state codes, opcodes,
// ALU/PC mux selects and the packed control-strobe bundle.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RDONE   = 4'd7,
    S_BEQ     = 4'd8,
    S_JUMP    = 4'd9,
    S_IEXEC   = 4'd10,
    S_IDONE   = 4'd11,
    S_BNE     = 4'd12,
    S_TRAP    = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  typedef struct packed {
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic       mem_to_reg;
    logic       ir_write;
    logic       mem_write;
    logic       mem_read;
    logic       iord;
    logic       pc_write_cond;
    logic       pc_write;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       branch_ne;
    logic       illegal_op;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control decode: current state plus effective memory-ready
// produce the full datapath strobe bundle.
module mc_ctrl_decode
  import mc_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PC_ALU;
        // Latch IR and bump PC only on the cycle the fetch completes.
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_BOFF;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_RDONE: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BEQ, S_BNE: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_ALUOUT;
        ctrl.branch_ne     = (state == S_BNE);
        ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      S_IEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_IDONE: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      // The faulting instruction is not retired, so only the trap strobe fires.
      S_TRAP: ctrl.illegal_op = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_fsm_controller.sv
// Multicycle MIPS control unit: owns the state register and next-state logic,
// and gates the decoded strobes off while reset is asserted.
module mc_fsm_controller
  import mc_pkg::*;
#(
  parameter bit MEM_WAIT = 1'b1,
  parameter bit EN_ADDI  = 1'b1,
  parameter bit EN_BNE   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic       mem_ready,
  output logic [3:0] S,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       MemToReg,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       MemRead,
  output logic       IorD,
  output logic       PCWriteCond,
  output logic       PCWrite,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       BranchNe,
  output logic       illegal_op,
  output logic       instr_done
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       rdy_eff;
  ctrl_t      ctrl_raw;
  ctrl_t      ctrl;

  assign rdy_eff = MEM_WAIT ? mem_ready : 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = rdy_eff ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if      (Op == OP_RTYPE)              state_d = S_EXEC;
        else if (Op == OP_LW || Op == OP_SW)  state_d = S_MEMADDR;
        else if (Op == OP_BEQ)                state_d = S_BEQ;
        else if (Op == OP_J)                  state_d = S_JUMP;
        else if (EN_ADDI && Op == OP_ADDI)    state_d = S_IEXEC;
        else if (EN_BNE && Op == OP_BNE)      state_d = S_BNE;
        else                                  state_d = S_TRAP;
      end
      // Op is still held by IR here, so it tells lw from sw.
      S_MEMADDR: state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = rdy_eff ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_d = rdy_eff ? S_FETCH : S_MEMWR;
      S_EXEC:    state_d = S_RDONE;
      S_IEXEC:   state_d = S_IDONE;
      default:   state_d = S_FETCH;
    endcase
  end

  mc_ctrl_decode u_decode (
    .state     (state_q),
    .mem_ready (rdy_eff),
    .ctrl      (ctrl_raw)
  );

  // Strobes are forced low for the whole reset window, not just after the edge.
  assign ctrl = rst ? '0 : ctrl_raw;

  assign S           = state_q;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign MemToReg    = ctrl.mem_to_reg;
  assign IRWrite     = ctrl.ir_write;
  assign MemWrite    = ctrl.mem_write;
  assign MemRead     = ctrl.mem_read;
  assign IorD        = ctrl.iord;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign PCWrite     = ctrl.pc_write;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;
  assign PCSource    = ctrl.pc_source;
  assign BranchNe    = ctrl.branch_ne;
  assign illegal_op  = ctrl.illegal_op;
  assign instr_done  = ctrl.instr_done;

endmodule
